// File: rtl/uart_tx.sv
// Serial transmitter: start bit, 5..8 data bits LSB first, one or two stop bits,
// each bit held for N baud_ticks where N is selected per character at accept time.
module uart_tx #(
  parameter int OVS_NORM = 16,
  parameter int OVS_ALT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [4:0] word_length,
  input  logic       Num_stop_bits,
  input  logic       oversample_by_3,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(2 * OVS_NORM);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q, n_q;
  logic [3:0]    bit_q, wl_q;
  logic [7:0]    data_q;
  logic          two_stop_q, txd_q, done_q;

  logic [3:0]    wl_d;
  logic [CW-1:0] n_d, bit_last, stop_last;

  always_comb begin
    if (word_length < 5'd5)      wl_d = 4'd5;
    else if (word_length > 5'd8) wl_d = 4'd8;
    else                         wl_d = word_length[3:0];
  end

  assign n_d       = oversample_by_3 ? CW'(OVS_ALT) : CW'(OVS_NORM);
  assign bit_last  = n_q - CW'(1);
  // Two stop bits are one continuous 2N-tick period on the same counter.
  assign stop_last = two_stop_q ? (bit_last + n_q) : bit_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      bit_q      <= '0;
      wl_q       <= '0;
      data_q     <= '0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (tx_valid) begin
            state_q    <= START;
            data_q     <= tx_data;
            wl_q       <= wl_d;
            n_q        <= n_d;
            two_stop_q <= Num_stop_bits;
            cnt_q      <= '0;
            bit_q      <= '0;
            txd_q      <= 1'b0;
          end
        end
        START: if (baud_tick) begin
          if (cnt_q == bit_last) begin
            state_q <= DATA;
            cnt_q   <= '0;
            txd_q   <= data_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: if (baud_tick) begin
          if (cnt_q == bit_last) begin
            cnt_q <= '0;
            if (bit_q == wl_q - 4'd1) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              // Shift so the next bit to send always sits in data_q[0].
              bit_q  <= bit_q + 4'd1;
              data_q <= {1'b0, data_q[7:1]};
              txd_q  <= data_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: if (baud_tick) begin
          if (cnt_q == stop_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of frames plus hand sequences for back-to-back, reset abort
// and mid-frame config changes; a tick-level monitor checks each frame against a queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset, baud_tick, Num_stop_bits, oversample_by_3, tx_valid;
  logic [4:0] word_length;
  logic [7:0] tx_data;
  logic       tx_ready, txd, busy, tx_done;

  uart_tx dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .word_length(word_length),
    .Num_stop_bits(Num_stop_bits), .oversample_by_3(oversample_by_3),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .txd(txd),
    .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [4:0] wl;
    logic       s2;
    logic       o3;
    int         mode;
    int         ticks;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         wl;
    int         n;
    int         ticks;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_mode = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int clamp_wl(input logic [4:0] wl);
    if (wl < 5) return 5;
    if (wl > 8) return 8;
    return int'(wl);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic [4:0] wl, input logic o3,
                          input int ticks);
    exp_t e;
    e.d = d; e.wl = clamp_wl(wl); e.n = o3 ? 3 : 16; e.ticks = ticks;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) return;
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] wl, input logic s2,
                      input logic o3, input int ticks, input logic [4:0] post_wl);
    wait_ready();
    tx_data = d; word_length = wl; Num_stop_bits = s2; oversample_by_3 = o3;
    tx_valid = 1'b1;
    push_exp(d, wl, o3, ticks);
    @(posedge clk); #1;
    // Scramble config right after accept; the frame in flight must not notice.
    tx_valid = 1'b0;
    word_length = post_wl;
    Num_stop_bits = 1'($urandom);
    oversample_by_3 = 1'($urandom);
    tx_data = 8'($urandom);
  endtask

  // Tick generator: every cycle, every third cycle, or random.
  initial begin
    int phase;
    phase = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tick_mode)
        0: baud_tick = 1'b1;
        1: begin phase = (phase + 1) % 3; baud_tick = (phase == 0); end
        default: baud_tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: record txd at every counted tick, compare whole frame on tx_done.
  initial begin
    logic obs[$];
    exp_t e;
    int   bad, b;
    logic eb;
    forever begin
      @(negedge clk);
      if (reset) begin
        obs.delete();
      end else begin
        if (tx_done) begin
          if (exp_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("frame_len_%02h", e.d), obs.size(), e.ticks);
            bad = 0;
            for (int i = 0; i < obs.size(); i++) begin
              b = i / e.n;
              if (b == 0)         eb = 1'b0;
              else if (b <= e.wl) eb = e.d[b-1];
              else                eb = 1'b1;
              if (obs[i] !== eb) bad++;
            end
            chk($sformatf("frame_bits_%02h_badticks", e.d), bad, 0);
          end
          obs.delete();
        end
        if (busy && baud_tick) obs.push_back(txd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  vec_t tbl[9];
  int   bad_cnt;

  initial begin
    tbl[0] = '{8'hA5, 5'd8,  1'b0, 1'b0, 0, 160};
    tbl[1] = '{8'hE6, 5'd5,  1'b1, 1'b1, 1, 24};
    tbl[2] = '{8'h3C, 5'd0,  1'b0, 1'b1, 2, 21};
    tbl[3] = '{8'hC3, 5'd31, 1'b1, 1'b1, 0, 33};
    tbl[4] = '{8'h5A, 5'd6,  1'b1, 1'b0, 2, 144};
    tbl[5] = '{8'hFF, 5'd7,  1'b0, 1'b1, 1, 27};
    tbl[6] = '{8'h00, 5'd4,  1'b0, 1'b1, 0, 21};
    tbl[7] = '{8'h81, 5'd9,  1'b0, 1'b1, 2, 30};
    tbl[8] = '{8'h96, 5'd16, 1'b1, 1'b1, 1, 33};

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; word_length = 5'd8;
    Num_stop_bits = 1'b0; oversample_by_3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {txd, tx_ready, busy, tx_done}, 4'b1100);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      tick_mode = tbl[i].mode;
      send(tbl[i].d, tbl[i].wl, tbl[i].s2, tbl[i].o3, tbl[i].ticks, 5'($urandom));
    end

    // Word length dropped mid-frame: this frame keeps 8 bits, the next uses 5.
    tick_mode = 2;
    send(8'hA5, 5'd8, 1'b0, 1'b1, 30, 5'd5);
    send(8'h3C, 5'd5, 1'b0, 1'b1, 21, 5'd5);

    // tx_valid held across two characters: second start bit right after tx_done.
    wait_ready();
    tx_data = 8'h55; word_length = 5'd8; Num_stop_bits = 1'b0; oversample_by_3 = 1'b1;
    tx_valid = 1'b1;
    push_exp(8'h55, 5'd8, 1'b1, 30);
    @(posedge clk); #1;
    tx_data = 8'h0F;
    push_exp(8'h0F, 5'd8, 1'b1, 30);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(negedge clk);
        if (tx_done) seen = 1'b1;
      end
      chk("b2b_first_done", seen, 1'b1);
    end
    @(negedge clk);
    chk("b2b_no_gap", {busy, txd}, 2'b10);
    @(posedge clk); #1;
    tx_valid = 1'b0;

    // Reset during DATA bit 3 with a competing tx_valid.
    wait_ready();
    tick_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    tx_data = 8'hA5; word_length = 5'd8; Num_stop_bits = 1'b0; oversample_by_3 = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("abort_in_bit3", {busy, txd}, 2'b10);
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h33;
    @(posedge clk); #1;
    chk("abort_outputs", {txd, tx_ready, busy, tx_done}, 4'b1100);
    reset = 1'b0; tx_valid = 1'b0;
    bad_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || !txd || tx_done) bad_cnt++;
    end
    chk("abort_quiet_cycles", bad_cnt, 0);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
